// File: rtl/memtrace_pkg.sv
// Shared types for the memory-trace request issuer: FSM states and the per-lane trace record.
package memtrace_pkg;

  localparam int MT_DATA_WIDTH    = 64;
  localparam int MT_LOGSIZE_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} issuer_state_e;

  typedef struct packed {
    logic [MT_DATA_WIDTH-1:0]    address;
    logic                        is_store;
    logic [MT_LOGSIZE_WIDTH-1:0] size;
    logic [MT_DATA_WIDTH-1:0]    data;
  } trace_rec_t;

endpackage

// File: rtl/memtrace_lane_fifo.sv
// Per-lane synchronous FIFO of trace records; head is a registered entry, so a push into an
// empty FIFO only becomes visible on the following cycle.
module memtrace_lane_fifo
  import memtrace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  trace_rec_t             push_data,
  input  logic                   pop,
  output trace_rec_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  trace_rec_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/memtrace_req_issuer.sv
// Drives the trace reader, buffers per-lane records and issues them as tagged memory requests.
// Optional statistics counters are built only when MEMTRACE_ISSUER_STATS_EN is defined.
module memtrace_req_issuer
  import memtrace_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = MT_DATA_WIDTH,
  parameter int LOGSIZE_WIDTH = MT_LOGSIZE_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int SOURCE_WIDTH  = 4,
  parameter int MAX_INFLIGHT  = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  output logic [63:0]                       trace_read_cycle,
  output logic                              trace_read_ready,
  input  logic [NUM_LANES-1:0]              trace_read_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   trace_read_address,
  input  logic [NUM_LANES-1:0]              trace_read_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_read_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   trace_read_data,
  input  logic                              trace_read_finished,
  output logic [NUM_LANES-1:0]              req_valid,
  input  logic [NUM_LANES-1:0]              req_ready,
  output logic [DATA_WIDTH*NUM_LANES-1:0]   req_address,
  output logic [DATA_WIDTH*NUM_LANES-1:0]   req_data,
  output logic [NUM_LANES-1:0]              req_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] req_size,
  output logic [SOURCE_WIDTH*NUM_LANES-1:0] req_source,
  input  logic [NUM_LANES-1:0]              resp_valid,
  output logic                              done,
  output logic                              err_underflow,
  output logic [32*NUM_LANES-1:0]           stat_issued,
  output logic [31:0]                       stat_stall_cycles
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  issuer_state_e        state;
  logic                 ready_q;
  logic [63:0]          cycle_q;
  logic                 finish_seen;
  logic                 issuing;
  logic                 all_idle;
  logic [NUM_LANES-1:0] lane_room;
  logic [NUM_LANES-1:0] lane_idle;
  logic [NUM_LANES-1:0] fire;
  logic [NUM_LANES-1:0] underflow;

  // The reply to a query lands one cycle later, so ready_q stands in for a slot already claimed.
  assign finish_seen      = ready_q && trace_read_finished;
  assign trace_read_ready = (state == RUN) && !finish_seen && (&lane_room);
  assign trace_read_cycle = cycle_q;
  assign issuing          = (state == RUN) || (state == DRAIN);
  assign all_idle         = &lane_idle;
  assign err_underflow    = |underflow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (finish_seen) state <= DRAIN;
        DRAIN:   if (all_idle) begin
                   state <= DONE;
                   done  <= 1'b1;
                 end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      cycle_q <= '0;
    end else begin
      ready_q <= trace_read_ready;
      if (trace_read_ready) cycle_q <= cycle_q + 64'd1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    trace_rec_t              in_rec;
    trace_rec_t              head;
    logic [CW-1:0]           count;
    logic                    empty;
    logic [IW-1:0]           inflight;
    logic [SOURCE_WIDTH-1:0] source;
    logic                    uf;

    assign in_rec.address  = trace_read_address[g*DATA_WIDTH +: DATA_WIDTH];
    assign in_rec.is_store = trace_read_is_store[g];
    assign in_rec.size     = trace_read_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
    assign in_rec.data     = trace_read_data[g*DATA_WIDTH +: DATA_WIDTH];

    memtrace_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (ready_q && trace_read_valid[g]),
      .push_data (in_rec),
      .pop       (fire[g]),
      .head      (head),
      .count     (count),
      .empty     (empty)
    );

    assign lane_room[g] = (int'(count) + int'(ready_q)) < FIFO_DEPTH;
    assign lane_idle[g] = empty && (inflight == '0);
    assign req_valid[g] = !empty && (inflight < IW'(MAX_INFLIGHT)) && issuing;
    assign fire[g]      = req_valid[g] && req_ready[g];
    assign underflow[g] = uf;

    assign req_address[g*DATA_WIDTH +: DATA_WIDTH]       = head.address;
    assign req_data[g*DATA_WIDTH +: DATA_WIDTH]          = head.data;
    assign req_is_store[g]                               = head.is_store;
    assign req_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]    = head.size;
    assign req_source[g*SOURCE_WIDTH +: SOURCE_WIDTH]    = source;

    // A response with nothing outstanding is flagged and never lets the count wrap below zero.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        inflight <= '0;
        source   <= '0;
        uf       <= 1'b0;
      end else begin
        if (fire[g]) source <= source + 1'b1;
        if (fire[g] && !resp_valid[g]) begin
          inflight <= inflight + 1'b1;
        end else if (!fire[g] && resp_valid[g]) begin
          if (inflight == '0) uf <= 1'b1;
          else                inflight <= inflight - 1'b1;
        end
      end
    end

`ifdef MEMTRACE_ISSUER_STATS_EN
    logic [31:0] issued_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                          issued_q <= '0;
      else if (fire[g] && (issued_q != '1))  issued_q <= issued_q + 32'd1;
    end

    assign stat_issued[g*32 +: 32] = issued_q;
`else
    assign stat_issued[g*32 +: 32] = '0;
`endif
  end

`ifdef MEMTRACE_ISSUER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if ((state == RUN) && !trace_read_ready && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stat_stall_cycles = stall_q;
`else
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_memtrace_req_issuer.sv
// Randomised bench for memtrace_req_issuer against a queue-based reference model of the issuer.
module tb_memtrace_req_issuer;

  localparam int NL = 4, DW = 64, LW = 8, SW = 4, DEPTH = 4, MAXI = 8;

  typedef struct {
    logic [63:0] addr;
    logic        st;
    logic [7:0]  size;
    logic [63:0] data;
  } rec_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [63:0]       trace_read_cycle;
  logic              trace_read_ready;
  logic [NL-1:0]     trace_read_valid = '0;
  logic [DW*NL-1:0]  trace_read_address = '0;
  logic [NL-1:0]     trace_read_is_store = '0;
  logic [LW*NL-1:0]  trace_read_size = '0;
  logic [DW*NL-1:0]  trace_read_data = '0;
  logic              trace_read_finished = 1'b0;
  logic [NL-1:0]     req_valid;
  logic [NL-1:0]     req_ready = '0;
  logic [DW*NL-1:0]  req_address;
  logic [DW*NL-1:0]  req_data;
  logic [NL-1:0]     req_is_store;
  logic [LW*NL-1:0]  req_size;
  logic [SW*NL-1:0]  req_source;
  logic [NL-1:0]     resp_valid = '0;
  logic              done;
  logic              err_underflow;
  logic [32*NL-1:0]  stat_issued;
  logic [31:0]       stat_stall_cycles;

  int checks = 0;
  int errors = 0;

  int          m_phase;
  bit          m_rq;
  logic [63:0] m_cyc;
  bit          m_err;
  int          m_stall;
  int          m_infl   [NL];
  int          m_src    [NL];
  int          m_issued [NL];
  rec_t        mq [NL][$];

  memtrace_req_issuer dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .trace_read_cycle    (trace_read_cycle),
    .trace_read_ready    (trace_read_ready),
    .trace_read_valid    (trace_read_valid),
    .trace_read_address  (trace_read_address),
    .trace_read_is_store (trace_read_is_store),
    .trace_read_size     (trace_read_size),
    .trace_read_data     (trace_read_data),
    .trace_read_finished (trace_read_finished),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_address         (req_address),
    .req_data            (req_data),
    .req_is_store        (req_is_store),
    .req_size            (req_size),
    .req_source          (req_source),
    .resp_valid          (resp_valid),
    .done                (done),
    .err_underflow       (err_underflow),
    .stat_issued         (stat_issued),
    .stat_stall_cycles   (stat_stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    m_phase = 0;
    m_rq    = 0;
    m_cyc   = '0;
    m_err   = 0;
    m_stall = 0;
    for (int g = 0; g < NL; g++) begin
      m_infl[g]   = 0;
      m_src[g]    = 0;
      m_issued[g] = 0;
      mq[g].delete();
    end
  endtask

  // A query is allowed only while running, the trace is not known to be over, and every lane
  // has room for its current contents plus the reply that may still be on its way.
  function automatic bit expReady(input bit fin);
    bit r;
    r = (m_phase == 1) && !(m_rq && fin);
    for (int g = 0; g < NL; g++)
      if (mq[g].size() + int'(m_rq) >= DEPTH) r = 0;
    return r;
  endfunction

  function automatic logic [63:0] expStat(input int v);
`ifdef MEMTRACE_ISSUER_STATS_EN
    return 64'(v);
`else
    return (v > -1) ? 64'd0 : 64'd0;
`endif
  endfunction

  // Called at a falling edge: drive one cycle of inputs, check outputs, then advance the model
  // to match what the next rising edge does.
  task automatic applyStimulus(input int ncyc, input int rdy_pct, input int resp_pct,
                               input bit fin, input logic [NL-1:0] uf_mask);
    rec_t          cur [NL];
    bit            er, idle;
    logic [NL-1:0] ev, fire;
    for (int c = 0; c < ncyc; c++) begin
      trace_read_finished = fin;
      for (int g = 0; g < NL; g++) begin
        cur[g].addr = {$urandom, $urandom};
        cur[g].st   = 1'($urandom_range(0, 1));
        cur[g].size = 8'($urandom_range(0, 3));
        cur[g].data = {$urandom, $urandom};
        trace_read_valid[g]              = ($urandom_range(0, 99) < 60);
        trace_read_address[g*DW +: DW]   = cur[g].addr;
        trace_read_is_store[g]           = cur[g].st;
        trace_read_size[g*LW +: LW]      = cur[g].size;
        trace_read_data[g*DW +: DW]      = cur[g].data;
        req_ready[g]  = ($urandom_range(0, 99) < rdy_pct);
        resp_valid[g] = uf_mask[g] || ((m_infl[g] > 0) && ($urandom_range(0, 99) < resp_pct));
      end
      #1;
      er = expReady(fin);
      checkOutput("ready", 64'(trace_read_ready), 64'(er));
      checkOutput("cycle", trace_read_cycle, m_cyc);
      checkOutput("done", 64'(done), 64'(m_phase == 3));
      checkOutput("err_underflow", 64'(err_underflow), 64'(m_err));
      checkOutput("stat_stall", 64'(stat_stall_cycles), expStat(m_stall));
      for (int g = 0; g < NL; g++) begin
        ev[g] = (mq[g].size() > 0) && (m_infl[g] < MAXI) && (m_phase == 1 || m_phase == 2);
        checkOutput($sformatf("req_valid%0d", g), 64'(req_valid[g]), 64'(ev[g]));
        if (ev[g]) begin
          checkOutput($sformatf("req_address%0d", g), req_address[g*DW +: DW], mq[g][0].addr);
          checkOutput($sformatf("req_data%0d", g), req_data[g*DW +: DW], mq[g][0].data);
          checkOutput($sformatf("req_is_store%0d", g), 64'(req_is_store[g]), 64'(mq[g][0].st));
          checkOutput($sformatf("req_size%0d", g), 64'(req_size[g*LW +: LW]), 64'(mq[g][0].size));
          checkOutput($sformatf("req_source%0d", g), 64'(req_source[g*SW +: SW]), 64'(m_src[g]));
        end
        checkOutput($sformatf("stat_issued%0d", g), 64'(stat_issued[g*32 +: 32]),
                    expStat(m_issued[g]));
        fire[g] = ev[g] && req_ready[g];
      end

      idle = 1;
      for (int g = 0; g < NL; g++)
        if (mq[g].size() != 0 || m_infl[g] != 0) idle = 0;
      for (int g = 0; g < NL; g++) begin
        if (fire[g]) begin
          void'(mq[g].pop_front());
          m_src[g] = (m_src[g] + 1) % (1 << SW);
          m_issued[g]++;
        end
        if (m_rq && trace_read_valid[g]) mq[g].push_back(cur[g]);
        if (fire[g] && !resp_valid[g]) m_infl[g]++;
        else if (!fire[g] && resp_valid[g]) begin
          if (m_infl[g] == 0) m_err = 1;
          else                m_infl[g]--;
        end
      end
      if (er) m_cyc = m_cyc + 64'd1;
      if (m_phase == 1 && !er) m_stall++;
      case (m_phase)
        0:       m_phase = 1;
        1:       if (m_rq && fin) m_phase = 2;
        2:       if (idle) m_phase = 3;
        default: m_phase = m_phase;
      endcase
      m_rq = er;
      @(negedge clock);
    end
  endtask

  task automatic checkResetOutputs(input string where);
    checkOutput({where, "_ready"}, 64'(trace_read_ready), 64'd0);
    checkOutput({where, "_cycle"}, trace_read_cycle, 64'd0);
    checkOutput({where, "_req_valid"}, 64'(req_valid), 64'd0);
    checkOutput({where, "_done"}, 64'(done), 64'd0);
    checkOutput({where, "_err"}, 64'(err_underflow), 64'd0);
    checkOutput({where, "_addr"}, 64'(|req_address), 64'd0);
    checkOutput({where, "_source"}, 64'(|req_source), 64'd0);
    checkOutput({where, "_issued"}, 64'(|stat_issued), 64'd0);
    checkOutput({where, "_stall"}, 64'(stat_stall_cycles), 64'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic midReset();
    #3 reset_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    resetModel();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    resetModel();
    @(negedge clock);
    @(negedge clock);
    checkResetOutputs("rst");
    reset_n = 1'b1;

    applyStimulus(40, 100, 50, 1'b0, '0);
    applyStimulus(20, 0, 0, 1'b0, '0);
    applyStimulus(30, 100, 0, 1'b0, '0);
    applyStimulus(200, 70, 40, 1'b0, '0);
    for (int i = 0; i < 400 && m_phase != 3; i++) applyStimulus(1, 70, 80, 1'b1, '0);
    #1 checkOutput("done_reached", 64'(done), 64'd1);

    applyStimulus(1, 100, 0, 1'b1, 4'b0001);
    applyStimulus(5, 100, 0, 1'b1, '0);
    #1 checkOutput("err_sticky", 64'(err_underflow), 64'd1);

    midReset();
    applyStimulus(150, 60, 40, 1'b0, '0);
    midReset();
    applyStimulus(100, 80, 30, 1'b0, '0);
    for (int i = 0; i < 400 && m_phase != 3; i++) applyStimulus(1, 80, 80, 1'b1, '0);
    #1 checkOutput("done_reached2", 64'(done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
